// File: rtl/sd_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sd_wb_arbiter
//  Description : Two-master Wishbone arbiter sharing the SD core's external
//                master port. Round-robin grant held for a master's whole
//                cyc tenure, with an ack watchdog that aborts stalled strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int CNT_W          = 10
) (
    input  logic        clk_50,
    input  logic        reset_n,

    // Requester 0: SD block-transfer engine
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    // Requester 1: secondary master
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    // Shared Wishbone master port
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,

    // Status
    output logic [1:0]  grant,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Watchdog fires while the counter holds TIMEOUT_CYCLES-1, i.e. on the
    // TIMEOUT_CYCLES-th consecutive unacked strobe cycle.
    localparam logic             C_WDG_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] C_CNT_LAST = (TIMEOUT_CYCLES > 0) ?
                                              CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_last;
    logic               w_last_next;
    logic [CNT_W-1:0]   r_wdg_cnt;
    logic               r_abort;
    logic               r_timeout_flag;

    logic [1:0]         w_grant;
    logic [31:0]        w_sel_adr;
    logic [31:0]        w_sel_dat;
    logic [3:0]         w_sel_sel;
    logic               w_sel_cyc;
    logic               w_sel_stb;
    logic               w_sel_we;
    logic [2:0]         w_sel_cti;
    logic [1:0]         w_sel_bte;
    logic               w_granted;
    logic               w_wdg_hit;

    // State and last-owner registers; last resets to 1 so m0 wins first contention
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_last  <= w_last_next;
        end
    end

    // Next-state logic: round-robin on contention, grant held until owner drops cyc
    always_comb begin
        w_state_next = r_state;
        w_last_next  = r_last;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_next = r_last ? GRANT0 : GRANT1;
                end else if (m0_cyc_i) begin
                    w_state_next = GRANT0;
                end else if (m1_cyc_i) begin
                    w_state_next = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_cyc_i) begin
                    w_last_next  = 1'b0;
                    w_state_next = m1_cyc_i ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!m1_cyc_i) begin
                    w_last_next  = 1'b1;
                    w_state_next = m0_cyc_i ? GRANT0 : IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Bus multiplexer: owner's signals pass straight through, everything 0 when idle
    always_comb begin
        w_grant   = 2'b00;
        w_sel_adr = '0;
        w_sel_dat = '0;
        w_sel_sel = '0;
        w_sel_cyc = 1'b0;
        w_sel_stb = 1'b0;
        w_sel_we  = 1'b0;
        w_sel_cti = '0;
        w_sel_bte = '0;
        case (r_state)
            GRANT0: begin
                w_grant   = 2'b01;
                w_sel_adr = m0_adr_i;
                w_sel_dat = m0_dat_i;
                w_sel_sel = m0_sel_i;
                w_sel_cyc = m0_cyc_i;
                w_sel_stb = m0_stb_i;
                w_sel_we  = m0_we_i;
                w_sel_cti = m0_cti_i;
                w_sel_bte = m0_bte_i;
            end
            GRANT1: begin
                w_grant   = 2'b10;
                w_sel_adr = m1_adr_i;
                w_sel_dat = m1_dat_i;
                w_sel_sel = m1_sel_i;
                w_sel_cyc = m1_cyc_i;
                w_sel_stb = m1_stb_i;
                w_sel_we  = m1_we_i;
                w_sel_cti = m1_cti_i;
                w_sel_bte = m1_bte_i;
            end
            default: begin
            end
        endcase
    end

    assign w_granted = |w_grant;

    assign wbm_adr_o = w_sel_adr;
    assign wbm_dat_o = w_sel_dat;
    assign wbm_sel_o = w_sel_sel;
    assign wbm_cyc_o = w_sel_cyc;
    assign wbm_stb_o = w_sel_stb & ~r_abort;
    assign wbm_we_o  = w_sel_we;
    assign wbm_cti_o = w_sel_cti;
    assign wbm_bte_o = w_sel_bte;

    // A late ack in the limit cycle wins over the abort
    assign w_wdg_hit = C_WDG_EN & w_granted & wbm_stb_o & ~wbm_ack_i &
                       (r_wdg_cnt == C_CNT_LAST);

    // Return path is purely combinational; only the owner sees ack/err
    assign m0_dat_o = wbm_dat_i;
    assign m1_dat_o = wbm_dat_i;
    assign m0_ack_o = wbm_ack_i & w_grant[0];
    assign m1_ack_o = wbm_ack_i & w_grant[1];
    assign m0_err_o = w_wdg_hit & w_grant[0];
    assign m1_err_o = w_wdg_hit & w_grant[1];

    assign grant        = w_grant;
    assign timeout_flag = r_timeout_flag;

    // Watchdog: count consecutive unacked strobes, abort and flag on the limit
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_wdg_cnt      <= '0;
            r_abort        <= 1'b0;
            r_timeout_flag <= 1'b0;
        end else if (w_wdg_hit) begin
            r_wdg_cnt      <= '0;
            r_abort        <= 1'b1;
            r_timeout_flag <= 1'b1;
        end else begin
            if (!C_WDG_EN || !w_granted || !wbm_stb_o || wbm_ack_i) begin
                r_wdg_cnt <= '0;
            end else begin
                r_wdg_cnt <= r_wdg_cnt + 1'b1;
            end
            // Abort holds the strobe off until the owner ends the access
            if (r_abort && (!w_sel_stb || !w_sel_cyc)) begin
                r_abort <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sd_wb_arbiter.md
# sd_wb_arbiter

Two-master Wishbone arbiter that shares the single external Wishbone master port of the SD device core. Requester 0 is the SD block-transfer engine (512-byte read/write bursts to/from BRAM); requester 1 is a secondary master (register/status writer or debug DMA). Grants are round-robin and held for a master's whole `cyc` tenure, so bursts are never split. A watchdog aborts transfers whose slave never acks.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 1023: consecutive unacked `stb` cycles before abort; 0 disables watchdog.
- `CNT_W`, 10: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk_50` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `mN_adr_i` in 32, `mN_dat_i` in 32, `mN_sel_i` in 4, `mN_cyc_i` in 1, `mN_stb_i` in 1, `mN_we_i` in 1, `mN_cti_i` in 3, `mN_bte_i` in 2 (N = 0, 1): requester-side Wishbone master signals.
- `mN_dat_o` out 32: read data (broadcast `wbm_dat_i`).
- `mN_ack_o` out 1: ack, routed to granted master only.
- `mN_err_o` out 1: one-cycle watchdog abort pulse.
- `wbm_adr_o` out 32, `wbm_dat_o` out 32, `wbm_sel_o` out 4, `wbm_cyc_o` out 1, `wbm_stb_o` out 1, `wbm_we_o` out 1, `wbm_cti_o` out 3, `wbm_bte_o` out 2: shared bus.
- `wbm_dat_i` in 32, `wbm_ack_i` in 1: shared bus returns.
- `grant` out 2: one-hot current owner (00 = idle).
- `timeout_flag` out 1: sticky, set on any abort, cleared only by reset.

## Operation
- States: IDLE, GRANT0, GRANT1 (registered). `last` register records last-granted master; resets to 1 so master 0 wins first contention.
- IDLE: only m0 cyc -> GRANT0; only m1 -> GRANT1; both -> master ≠ `last`; none -> stay.
- GRANTn: bus outputs combinationally mux mN inputs; `wbm_cyc_o`/`wbm_stb_o` = mN cyc/stb (stb additionally gated by abort).
- GRANTn with mN_cyc_i low: if other master's cyc high, go directly to its GRANT state; else IDLE. `last` <= n.
- IDLE: all `wbm_*` outputs driven 0.
- `mN_ack_o` = `wbm_ack_i` & grant[n]; non-granted master always sees ack 0, err 0.
- Watchdog: counter clears when not granted, stb low, or `wbm_ack_i` high; otherwise increments. When it reaches TIMEOUT_CYCLES: `mN_err_o` pulses one cycle, counter clears, abort flag set, `timeout_flag` set. While abort set, `wbm_stb_o` forced 0; abort clears when granted master drops stb or cyc. Grant is not revoked by abort; master must drop cyc.

## Timing
- Reset values: state IDLE, grant 00, all `wbm_*` outputs 0, all `mN_ack_o`/`mN_err_o` 0, counter 0, abort 0, `timeout_flag` 0, `last` 1.
- Arbitration latency: cyc rising in IDLE -> forwarded on the following cycle (1 cycle).
- Handover: owner drops cyc in cycle T -> bus cyc low in T; other master forwarded in T+1 (no extra idle cycle).
- Ack/data path purely combinational (zero added latency), so classic and incrementing bursts (cti 010/111) pass unchanged.
- Watchdog: err asserted on the TIMEOUT_CYCLES-th consecutive unacked stb cycle; ack in that same cycle takes precedence (no err).
- Reset mid-burst: immediate return to reset values; in-flight transfer is abandoned.

## Test plan
- Reset: reset_n low with both cyc high -> all bus outputs 0, grant 00; release -> grant 01 one cycle later.
- Contention: both cyc high from IDLE, m0 16-beat burst then drops cyc -> grant 10 next cycle, m1 ack count 0 during m0 burst, 16 acks to m0.
- Round-robin: both hold cyc, each drops after 1 beat and immediately re-requests -> grant sequence 01,10,01,10.
- Burst integrity: m1 requests during m0 burst (cti 010...111, 128 beats) -> no grant change until m0 cyc low; all 128 addresses forwarded in order.
- Watchdog: TIMEOUT_CYCLES=8, slave never acks m0 -> m0_err_o pulse on 8th stb cycle, wbm_stb_o 0 afterwards, timeout_flag 1; m0 drops cyc -> IDLE.
- Ack at limit: ack arrives on exactly the 8th cycle -> no err, timeout_flag stays 0.
